// File: rtl/time_report_gen_pkg.sv
// Shared constants and state encoding for the time report frame generator.
// Holds the ASCII characters used in a frame and the fixed frame length.
package time_report_gen_pkg;

   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam int         FRAME_LEN   = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/time_report_gen_bin2ascii2.sv
// Combinational 7-bit binary to two ASCII decimal digits.
// Values above 99 saturate to "99".
module bin2ascii2
   import time_report_gen_pkg::*;
(
   input  logic [6:0] value,
   output logic [7:0] tens,
   output logic [7:0] units
);

   logic [6:0] sat;

   always_comb begin
      sat   = (value > 7'd99) ? 7'd99 : value;
      tens  = ASCII_ZERO + {1'b0, sat / 7'd10};
      units = ASCII_ZERO + {1'b0, sat % 7'd10};
   end

endmodule

// File: rtl/time_report_gen.sv
// Formats a watch or stopwatch time snapshot into a 10-byte ASCII frame
// and pushes it byte by byte into a TX FIFO, honouring the FIFO full flag.
module time_report_gen
   import time_report_gen_pkg::*;
#(
   parameter int FRAME_LEN = time_report_gen_pkg::FRAME_LEN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       mode,
   input  logic [6:0] f_hi,
   input  logic [6:0] f_mid,
   input  logic [6:0] f_lo,
   input  logic       full,
   output logic       push,
   output logic [7:0] push_data,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] LAST_COUNT = 4'(FRAME_LEN);

   state_t     state, state_next;
   logic [3:0] idx, idx_next;
   logic       snap_mode, snap_mode_next;
   logic [6:0] snap_hi, snap_hi_next;
   logic [6:0] snap_mid, snap_mid_next;
   logic [6:0] snap_lo, snap_lo_next;
   logic       push_next, busy_next, done_next;
   logic [7:0] data_next;

   logic       src_mode;
   logic [6:0] src_hi, src_mid, src_lo;
   logic [3:0] sel_idx;
   logic [7:0] hi_tens, hi_units, mid_tens, mid_units, lo_tens, lo_units;
   logic [7:0] cur_byte;

   // In IDLE the first byte is built from the live inputs so it can be
   // pushed in the very next cycle; afterwards only the snapshot is used.
   always_comb begin
      src_mode = (state == IDLE) ? mode  : snap_mode;
      src_hi   = (state == IDLE) ? f_hi  : snap_hi;
      src_mid  = (state == IDLE) ? f_mid : snap_mid;
      src_lo   = (state == IDLE) ? f_lo  : snap_lo;
      sel_idx  = (state == IDLE) ? 4'd0  : idx;
   end

   bin2ascii2 u_conv_hi  (.value(src_hi),  .tens(hi_tens),  .units(hi_units));
   bin2ascii2 u_conv_mid (.value(src_mid), .tens(mid_tens), .units(mid_units));
   bin2ascii2 u_conv_lo  (.value(src_lo),  .tens(lo_tens),  .units(lo_units));

   always_comb begin
      case (sel_idx)
         4'd0:    cur_byte = hi_tens;
         4'd1:    cur_byte = hi_units;
         4'd2:    cur_byte = ASCII_COLON;
         4'd3:    cur_byte = mid_tens;
         4'd4:    cur_byte = mid_units;
         4'd5:    cur_byte = src_mode ? ASCII_DOT : ASCII_COLON;
         4'd6:    cur_byte = lo_tens;
         4'd7:    cur_byte = lo_units;
         4'd8:    cur_byte = ASCII_CR;
         4'd9:    cur_byte = ASCII_LF;
         default: cur_byte = 8'h00;
      endcase
   end

   // idx counts bytes already scheduled; once it reaches the frame length
   // the frame is complete and the next cycle reports done.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      snap_mode_next = snap_mode;
      snap_hi_next   = snap_hi;
      snap_mid_next  = snap_mid;
      snap_lo_next   = snap_lo;
      push_next      = 1'b0;
      data_next      = 8'h00;
      busy_next      = busy;
      done_next      = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               state_next     = SEND;
               snap_mode_next = mode;
               snap_hi_next   = f_hi;
               snap_mid_next  = f_mid;
               snap_lo_next   = f_lo;
               busy_next      = 1'b1;
               idx_next       = 4'd0;
               if (!full) begin
                  push_next = 1'b1;
                  data_next = cur_byte;
                  idx_next  = 4'd1;
               end
            end
         end
         SEND: begin
            if (idx == LAST_COUNT) begin
               state_next = DONE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else if (!full) begin
               push_next = 1'b1;
               data_next = cur_byte;
               idx_next  = idx + 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= 4'd0;
         snap_mode <= 1'b0;
         snap_hi   <= 7'd0;
         snap_mid  <= 7'd0;
         snap_lo   <= 7'd0;
         push      <= 1'b0;
         push_data <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         snap_mode <= snap_mode_next;
         snap_hi   <= snap_hi_next;
         snap_mid  <= snap_mid_next;
         snap_lo   <= snap_lo_next;
         push      <= push_next;
         push_data <= data_next;
         busy      <= busy_next;
         done      <= done_next;
      end
   end

endmodule

// File: tb/tb_time_report_gen.sv
// Self-checking bench for time_report_gen: directed frames plus randomized
// frames with random FIFO back-pressure, checked against a textual frame model.
module tb_time_report_gen;

   localparam int FRAME = 10;

   logic       clk;
   logic       rst;
   logic       req;
   logic       mode;
   logic [6:0] f_hi, f_mid, f_lo;
   logic       full;
   logic       push;
   logic [7:0] push_data;
   logic       busy;
   logic       done;

   int checks;
   int failures;

   time_report_gen dut (
      .clk(clk), .rst(rst), .req(req), .mode(mode),
      .f_hi(f_hi), .f_mid(f_mid), .f_lo(f_lo), .full(full),
      .push(push), .push_data(push_data), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // Reference: the k-th character of "HH:MM:SS\r\n" / "MM:SS.CC\r\n".
   function automatic logic [7:0] modelByte(input logic m, input int h, input int mi,
                                            input int l, input int k);
      int v[3];
      v[0] = (h  > 99) ? 99 : h;
      v[1] = (mi > 99) ? 99 : mi;
      v[2] = (l  > 99) ? 99 : l;
      if (k == 8) return 8'h0D;
      if (k == 9) return 8'h0A;
      if (k % 3 == 2) return (k == 5 && m) ? 8'h2E : 8'h3A;
      if (k % 3 == 0) return 8'(48 + v[k / 3] / 10);
      return 8'(48 + v[k / 3] % 10);
   endfunction

   // Called at a negedge; fullMode 0 = never full, 1 = 5-cycle stall after
   // the 3rd byte, 2 = random full. disturb toggles req and inputs mid-frame.
   task automatic applyStimulus(input logic m, input int h, input int mi, input int l,
                                input int fullMode, input bit disturb);
      logic [7:0] got[$];
      int  stallLeft, stallCycles, doneCyc;
      bit  prevFull, sawDone, stallUsed;
      got.delete();
      stallLeft = 0; stallCycles = 0; doneCyc = 0;
      prevFull = 1'b0; sawDone = 1'b0; stallUsed = 1'b0;
      mode = m; f_hi = 7'(h); f_mid = 7'(mi); f_lo = 7'(l);
      full = 1'b0; req = 1'b1;
      for (int cyc = 1; cyc <= 400 && !sawDone; cyc++) begin
         @(negedge clk);
         if (prevFull && got.size() < FRAME) begin
            stallCycles++;
            checkOutput("no_push_after_full", push, 0);
         end
         if (!push) checkOutput("data_zero_without_push", push_data, 0);
         if (done) begin
            sawDone = 1'b1;
            doneCyc = cyc;
            checkOutput("busy_low_at_done", busy, 0);
            checkOutput("push_low_at_done", push, 0);
         end else begin
            checkOutput("busy_during_frame", busy, 1);
            if (push) got.push_back(push_data);
         end
         req = (disturb && !sawDone) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (disturb) begin
            mode  = 1'($urandom_range(0, 1));
            f_hi  = 7'($urandom_range(0, 127));
            f_mid = 7'($urandom_range(0, 127));
            f_lo  = 7'($urandom_range(0, 127));
         end
         if (fullMode == 1 && got.size() == 3 && !stallUsed) begin
            stallUsed = 1'b1;
            stallLeft = 5;
         end
         if (fullMode == 2) full = ($urandom_range(0, 2) == 0);
         else if (stallLeft > 0) begin
            full = 1'b1;
            stallLeft--;
         end else full = 1'b0;
         prevFull = full;
      end
      req = 1'b0;
      full = 1'b0;
      checkOutput("done_seen", sawDone, 1);
      checkOutput("frame_length", got.size(), FRAME);
      for (int k = 0; k < FRAME; k++)
         checkOutput($sformatf("byte%0d", k), (k < got.size()) ? got[k] : 8'hxx,
                     modelByte(m, h, mi, l, k));
      if (sawDone) checkOutput("done_latency", doneCyc, 11 + stallCycles);
      @(negedge clk);
      checkOutput("done_single_cycle", done, 0);
      checkOutput("idle_after_done", push, 0);
      checkOutput("busy_after_done", busy, 0);
   endtask

   task automatic resetMidFrame();
      int seen;
      seen = 0;
      mode = 1'b0; f_hi = 7'd13; f_mid = 7'd5; f_lo = 7'd9;
      full = 1'b0; req = 1'b1;
      for (int cyc = 0; cyc < 50 && seen < 4; cyc++) begin
         @(negedge clk);
         req = 1'b0;
         if (push) seen++;
      end
      checkOutput("reached_4th_byte", seen, 4);
      rst = 1'b0;
      #1;
      checkOutput("reset_push", push, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_data", push_data, 0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("held_reset_push", push, 0);
         checkOutput("held_reset_done", done, 0);
      end
      rst = 1'b1;
      applyStimulus(1'b0, 21, 47, 3, 0, 1'b0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0; req = 1'b0; mode = 1'b0; full = 1'b0;
      f_hi = 7'd0; f_mid = 7'd0; f_lo = 7'd0;
      repeat (3) @(negedge clk);
      checkOutput("init_push", push, 0);
      checkOutput("init_data", push_data, 0);
      checkOutput("init_busy", busy, 0);
      checkOutput("init_done", done, 0);
      rst = 1'b1;

      applyStimulus(1'b0, 13, 5, 9, 0, 1'b0);
      applyStimulus(1'b1, 59, 59, 99, 0, 1'b0);
      applyStimulus(1'b0, 13, 5, 9, 1, 1'b0);
      applyStimulus(1'b1, 7, 42, 88, 0, 1'b1);
      applyStimulus(1'b0, 120, 0, 100, 0, 1'b0);
      resetMidFrame();

      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            checkOutput("idle_no_push", push, 0);
         end
         applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 127),
                       $urandom_range(0, 127), $urandom_range(0, 127),
                       2, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
